// File: rtl/bus_receiver_if.sv
// Serial frame line plus received-frame results exchanged between
// the bus_receiver (slave) and whatever drives and consumes it (master).
interface bus_receiver_if;
  logic        bus_in;
  logic [63:0] data_out;
  logic [3:0]  crc_out;
  logic        data_valid;
  logic        crc_err;
  logic        addr_miss;
  logic        busy;

  modport slave (
    input  bus_in,
    output data_out, crc_out, data_valid, crc_err, addr_miss, busy
  );

  modport master (
    output bus_in,
    input  data_out, crc_out, data_valid, crc_err, addr_miss, busy
  );
endinterface

// File: rtl/bus_receiver.sv
// Serial frame receiver: start bit, 4-bit address, 64-bit data, 4-bit CRC, MSB first.
// Define BUS_RECEIVER_CRC_CHECK_EN to enable the CRC-4 (x^4+x+1) check of addressed frames.
module bus_receiver #(
  parameter logic [3:0] MY_ADDR = 4'd1
) (
  input logic            clock,
  input logic            reset,
  bus_receiver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CRC  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [6:0]  bit_cnt_r;
  logic [6:0]  bit_cnt_next_s;
  logic        shift_addr_s;
  logic        shift_data_s;
  logic        shift_crc_s;
  logic        frame_end_s;
  logic        done_r;
  logic [3:0]  addr_r;
  logic [63:0] data_r;
  logic [3:0]  crc_rx_r;
  logic        addr_hit_s;
  logic        crc_ok_s;
  logic        accept_s;
  logic        reject_s;
  logic        miss_s;
  logic [63:0] data_out_r;
  logic [3:0]  crc_out_r;
  logic        data_valid_r;
  logic        crc_err_r;
  logic        addr_miss_r;
  logic        busy_r;

`ifdef BUS_RECEIVER_CRC_CHECK_EN
  function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign crc_ok_s = (crc4_calc({addr_r, data_r}) == crc_rx_r);
`else
  assign crc_ok_s = 1'b1;
`endif

  // Frame is judged one cycle after its last CRC bit, while the shift registers still hold it.
  assign addr_hit_s = (addr_r == MY_ADDR);
  assign accept_s   = done_r & addr_hit_s & crc_ok_s;
  assign reject_s   = done_r & addr_hit_s & ~crc_ok_s;
  assign miss_s     = done_r & ~addr_hit_s;

  // Next-state and field-shift decode.
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_addr_s   = 1'b0;
    shift_data_s   = 1'b0;
    shift_crc_s    = 1'b0;
    frame_end_s    = 1'b0;
    case (state_r)
      IDLE: begin
        bit_cnt_next_s = 7'd0;
        if (bus.bus_in) begin
          state_next_s = ADDR;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADDR: begin
        shift_addr_s = 1'b1;
        if (bit_cnt_r == 7'd3) begin
          state_next_s   = DATA;
          bit_cnt_next_s = 7'd0;
        end else begin
          bit_cnt_next_s = bit_cnt_r + 7'd1;
        end
      end
      DATA: begin
        shift_data_s = 1'b1;
        if (bit_cnt_r == 7'd63) begin
          state_next_s   = CRC;
          bit_cnt_next_s = 7'd0;
        end else begin
          bit_cnt_next_s = bit_cnt_r + 7'd1;
        end
      end
      CRC: begin
        shift_crc_s = 1'b1;
        if (bit_cnt_r == 7'd3) begin
          state_next_s   = IDLE;
          bit_cnt_next_s = 7'd0;
          frame_end_s    = 1'b1;
        end else begin
          bit_cnt_next_s = bit_cnt_r + 7'd1;
        end
      end
      default: begin
        state_next_s   = IDLE;
        bit_cnt_next_s = 7'd0;
      end
    endcase
  end

  // State, bit counter and field shift registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= 7'd0;
      done_r    <= 1'b0;
      addr_r    <= 4'd0;
      data_r    <= 64'd0;
      crc_rx_r  <= 4'd0;
    end else begin
      state_r   <= state_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      done_r    <= frame_end_s;
      if (shift_addr_s) addr_r   <= {addr_r[2:0], bus.bus_in};
      if (shift_data_s) data_r   <= {data_r[62:0], bus.bus_in};
      if (shift_crc_s)  crc_rx_r <= {crc_rx_r[2:0], bus.bus_in};
    end
  end

  // Registered results and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_r   <= 64'd0;
      crc_out_r    <= 4'd0;
      data_valid_r <= 1'b0;
      crc_err_r    <= 1'b0;
      addr_miss_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_valid_r <= accept_s;
      crc_err_r    <= reject_s;
      addr_miss_r  <= miss_s;
      busy_r       <= (state_next_s != IDLE);
      if (accept_s) begin
        data_out_r <= data_r;
        crc_out_r  <= crc_rx_r;
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.crc_out    = crc_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.crc_err    = crc_err_r;
  assign bus.addr_miss  = addr_miss_r;
  assign bus.busy       = busy_r;

endmodule

// File: doc/bus_receiver.md
BUS_RECEIVER -- requirements
Module: bus_receiver

Interface
REQ-001 Parameter MY_ADDR, default 4'd1: node address this receiver accepts.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bus_in  input  1  serial frame line driven by the transmitting FPGA's bus_out; idle level 0.
REQ-005 data_out  output  64  payload of last accepted frame.
REQ-006 crc_out  output  4  CRC field of last accepted frame.
REQ-007 data_valid  output  1  one-cycle pulse: new frame accepted into data_out/crc_out.
REQ-008 crc_err  output  1  one-cycle pulse: addressed frame failed CRC check.
REQ-009 addr_miss  output  1  one-cycle pulse: complete frame for another address discarded.
REQ-010 busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-011 Frame format, one bit per clock, MSB first: start bit (1), address (4), data (64), CRC (4); 73 bits total.
REQ-012 bus_in shall be sampled on each rising clock edge; no oversampling, no resynchronisation.
REQ-013 FSM states IDLE, ADDR, DATA, CRC; 7-bit bit counter indexes the current field.
REQ-014 IDLE: bus_in=1 -> ADDR; bus_in=0 -> stay IDLE.
REQ-015 ADDR: shift in 4 bits, then -> DATA; DATA: shift in 64 bits, then -> CRC; CRC: shift in 4 bits, then -> IDLE.
REQ-016 A start bit shall be accepted in the cycle immediately after the last CRC bit (back-to-back frames, no guard gap).
REQ-017 Status pulses (data_valid, crc_err, addr_miss) shall be asserted in the cycle after the last CRC bit is sampled, for exactly one cycle.
REQ-018 Address != MY_ADDR: frame fully consumed, addr_miss pulsed, data_out/crc_out unchanged, no crc_err.
REQ-019 Address == MY_ADDR and CRC accepted: data_out/crc_out updated in the same cycle as data_valid pulse.
REQ-020 data_out/crc_out shall hold until the next accepted frame; no consumer handshake; a new frame overwrites them.
REQ-021 data_valid, crc_err, addr_miss shall be mutually exclusive.
REQ-022 A partial frame is not flushed by line inactivity; the FSM counts bits regardless of bus_in value once started.

Reset
REQ-023 Reset shall force FSM to IDLE, bit counter 0, data_out 0, crc_out 0, data_valid 0, crc_err 0, addr_miss 0, busy 0.
REQ-024 Reset asserted mid-frame shall abort the frame with no status pulse; reception restarts at the next start bit after reset deasserts.
REQ-025 Reset shall take priority over every other event in the same cycle.

Configuration
REQ-026 Macro BUS_RECEIVER_CRC_CHECK_EN selects CRC checking.
REQ-027 Defined: CRC-4, polynomial x^4+x+1, init 0, no reflection, no final XOR, over the 68 address+data bits MSB first; compared with received CRC field; mismatch on an addressed frame -> crc_err pulse, data_out/crc_out unchanged, no data_valid.
REQ-028 Not defined: no CRC logic; every addressed frame accepted, received CRC field passed to crc_out, crc_err tied 0.

Verification
REQ-029 Reset, then addr=1, data=64'h0, CRC=4'h5 -> data_valid pulse 74 cycles after start-bit sample cycle, data_out=0, crc_out=5, busy low afterwards.
REQ-030 addr=1, data=64'h1, CRC=4'h6 -> data_valid, data_out=1; same frame with CRC=4'h1 -> crc_err (with macro), data_valid with crc_out=1 (without macro).
REQ-031 addr=2, data=64'hDEADBEEF_00000000, any CRC -> addr_miss pulse, data_out retains previous value.
REQ-032 Two valid frames back-to-back (second start bit in cycle after first CRC LSB) -> two data_valid pulses 73 cycles apart, second payload on data_out.
REQ-033 Reset asserted at data bit 30 of a valid frame -> no pulse, outputs 0; following valid frame (addr=1, data=0, CRC=5) accepted normally.
